// File: rtl/timer_ctrl.sv
// Timer sequencer driving an external up-counter: load, prescaled increment, terminal-count irq.
// Define TIMER_CTRL_OVF_EN to build the missed-interrupt (ovf_o) flag.
module timer_ctrl #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned PRE_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 mode_i,
  input  logic [PRE_WIDTH-1:0] prescale_i,
  input  logic [WIDTH-1:0]     period_i,
  input  logic [WIDTH-1:0]     load_i,
  input  logic [WIDTH-1:0]     cnt_i,
  output logic                 cnt_clr_o,
  output logic                 cnt_en_o,
  output logic                 cnt_we_o,
  output logic [WIDTH-1:0]     cnt_dat_o,
  output logic                 irq_o,
  input  logic                 irq_ack_i,
  output logic                 busy_o,
  output logic                 ovf_o
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [PRE_WIDTH-1:0] presc_q, presc_d;
  logic                 mode_q, mode_d;
  logic [PRE_WIDTH-1:0] pre_q, pre_d;
  logic [WIDTH-1:0]     period_q, period_d;
  logic [WIDTH-1:0]     load_q, load_d;
  logic                 clr_q, clr_d;
  logic                 en_q, en_d;
  logic                 we_q, we_d;
  logic [WIDTH-1:0]     dat_q, dat_d;
  logic                 irq_q, irq_d;
  logic                 busy_q, busy_d;
  logic                 tick;
  logic                 match;

  // cnt_i is stale while a strobe we issued is still visible, so no compare then.
  assign tick = (state_q == StRun) && (presc_q == pre_q) && !(en_q || we_q);

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    mode_d   = mode_q;
    pre_d    = pre_q;
    period_d = period_q;
    load_d   = load_q;
    clr_d    = 1'b0;
    en_d     = 1'b0;
    we_d     = 1'b0;
    dat_d    = dat_q;
    match    = 1'b0;
    if (stop_i) begin
      clr_d   = 1'b1;
      state_d = StIdle;
      presc_d = '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            mode_d   = mode_i;
            pre_d    = prescale_i;
            period_d = period_i;
            load_d   = load_i;
            we_d     = 1'b1;
            dat_d    = load_i;
            presc_d  = '0;
            state_d  = StLoad;
          end
        end
        StLoad: begin
          presc_d = '0;
          state_d = StRun;
        end
        StRun: begin
          presc_d = (presc_q == pre_q) ? '0 : presc_q + PRE_WIDTH'(1);
          if (tick) begin
            if (cnt_i == period_q) begin
              match = 1'b1;
              if (mode_q) begin
                we_d  = 1'b1;
                dat_d = load_q;
              end else begin
                state_d = StDone;
              end
            end else begin
              en_d = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
    irq_d  = match | (irq_q & ~irq_ack_i);
    busy_d = (state_d == StLoad) || (state_d == StRun);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= StIdle;
      presc_q  <= '0;
      mode_q   <= 1'b0;
      pre_q    <= '0;
      period_q <= '0;
      load_q   <= '0;
      clr_q    <= 1'b0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      dat_q    <= '0;
      irq_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      mode_q   <= mode_d;
      pre_q    <= pre_d;
      period_q <= period_d;
      load_q   <= load_d;
      clr_q    <= clr_d;
      en_q     <= en_d;
      we_q     <= we_d;
      dat_q    <= dat_d;
      irq_q    <= irq_d;
      busy_q   <= busy_d;
    end
  end

  assign cnt_clr_o = clr_q;
  assign cnt_en_o  = en_q;
  assign cnt_we_o  = we_q;
  assign cnt_dat_o = dat_q;
  assign irq_o     = irq_q;
  assign busy_o    = busy_q;

`ifdef TIMER_CTRL_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = irq_ack_i ? 1'b0 : (ovf_q | (match & irq_q));
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with a behavioural downstream counter.
module tb_timer_ctrl;
  localparam int unsigned W  = 8;
  localparam int unsigned PW = 8;

  logic          clk = 1'b0;
  logic          rst_i, start_i, stop_i, mode_i, irq_ack_i;
  logic [PW-1:0] prescale_i;
  logic [W-1:0]  period_i, load_i, cnt_i;
  logic          cnt_clr_o, cnt_en_o, cnt_we_o, irq_o, busy_o, ovf_o;
  logic [W-1:0]  cnt_dat_o;
  logic [W-1:0]  cnt;

  int vectors     = 0;
  int miscompares = 0;

  timer_ctrl #(.WIDTH(W), .PRE_WIDTH(PW)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .mode_i     (mode_i),
    .prescale_i (prescale_i),
    .period_i   (period_i),
    .load_i     (load_i),
    .cnt_i      (cnt_i),
    .cnt_clr_o  (cnt_clr_o),
    .cnt_en_o   (cnt_en_o),
    .cnt_we_o   (cnt_we_o),
    .cnt_dat_o  (cnt_dat_o),
    .irq_o      (irq_o),
    .irq_ack_i  (irq_ack_i),
    .busy_o     (busy_o),
    .ovf_o      (ovf_o)
  );

  always #5 clk = ~clk;

  // Downstream counter: one-cycle latency from strobe to cnt_i.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i)         cnt <= '0;
    else if (cnt_clr_o) cnt <= '0;
    else if (cnt_we_o)  cnt <= cnt_dat_o;
    else if (cnt_en_o)  cnt <= cnt + 8'd1;
  end
  assign cnt_i = cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic e_en, e_we, e_irq, e_busy, e_ovf;
    rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; mode_i = 1'b0; irq_ack_i = 1'b0;
    prescale_i = '0; period_i = '0; load_i = '0;
    #2 rst_i = 1'b0;
    #1;
    check("rst_clr", cnt_clr_o, 0);
    check("rst_en", cnt_en_o, 0);
    check("rst_we", cnt_we_o, 0);
    check("rst_dat", cnt_dat_o, 0);
    check("rst_irq", irq_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ovf", ovf_o, 0);
    step(); step();
    rst_i = 1'b1;
    step();
    check("idle_busy", busy_o, 0);
    check("idle_clr", cnt_clr_o, 0);

    // One-shot, prescale 0, load 0, period 3
    mode_i = 1'b0; prescale_i = 8'd0; load_i = 8'd0; period_i = 8'd3; start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("os_load_we", cnt_we_o, 1);
    check("os_load_dat", cnt_dat_o, 0);
    check("os_load_busy", busy_o, 1);
    check("os_load_en", cnt_en_o, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      e_en   = (i == 1) || (i == 3) || (i == 5);
      e_irq  = (i == 7);
      e_busy = (i < 7);
      check($sformatf("os_en_%0d", i), cnt_en_o, e_en);
      check($sformatf("os_we_%0d", i), cnt_we_o, 0);
      check($sformatf("os_irq_%0d", i), irq_o, e_irq);
      check($sformatf("os_busy_%0d", i), busy_o, e_busy);
    end
    check("os_cnt_final", cnt_i, 3);
    step();
    check("done_irq", irq_o, 1);
    check("done_busy", busy_o, 0);
    check("done_en", cnt_en_o, 0);
    check("done_we", cnt_we_o, 0);
    check("done_ovf", ovf_o, 0);
    irq_ack_i = 1'b1;
    step();
    irq_ack_i = 1'b0;
    check("ack_irq", irq_o, 0);

    // Periodic, prescale 2, load 5, period 7: match every 9 cycles
    mode_i = 1'b1; prescale_i = 8'd2; load_i = 8'd5; period_i = 8'd7; start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c > 1) step();
      e_we   = (c == 1) || (c == 11) || (c == 20) || (c == 29);
      e_en   = (c == 5) || (c == 8) || (c == 14) || (c == 17) || (c == 23) || (c == 26);
      e_irq  = (c >= 11 && c <= 21) || (c >= 29);
`ifdef TIMER_CTRL_OVF_EN
      e_ovf  = (c == 20) || (c == 21);
`else
      e_ovf  = 1'b0;
`endif
      check($sformatf("per_we_%0d", c), cnt_we_o, e_we);
      check($sformatf("per_en_%0d", c), cnt_en_o, e_en);
      check($sformatf("per_irq_%0d", c), irq_o, e_irq);
      check($sformatf("per_ovf_%0d", c), ovf_o, e_ovf);
      check($sformatf("per_busy_%0d", c), busy_o, 1);
      check($sformatf("per_clr_%0d", c), cnt_clr_o, 0);
      if (e_we) check($sformatf("per_dat_%0d", c), cnt_dat_o, 5);
      if (c == 12) check("per_reload_cnt", cnt_i, 5);
      irq_ack_i = (c == 21) || (c == 28);
      start_i   = (c == 15);
    end
    irq_ack_i = 1'b0;
    start_i   = 1'b0;

    // Stop coincident with a tick and a start
    step();
    stop_i = 1'b1; start_i = 1'b1;
    step();
    stop_i = 1'b0; start_i = 1'b0;
    check("stop_clr", cnt_clr_o, 1);
    check("stop_en", cnt_en_o, 0);
    check("stop_we", cnt_we_o, 0);
    check("stop_busy", busy_o, 0);
    check("stop_irq", irq_o, 1);
    check("stop_ovf", ovf_o, 0);
    step();
    check("stop_clr_pulse", cnt_clr_o, 0);
    check("stop_idle_busy", busy_o, 0);
    check("stop_idle_we", cnt_we_o, 0);
    check("stop_cnt", cnt_i, 0);

    // Reset asserted mid-RUN
    mode_i = 1'b0; prescale_i = 8'd0; load_i = 8'd2; period_i = 8'd9; start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("mr_load_we", cnt_we_o, 1);
    step(); step();
    check("mr_run_en", cnt_en_o, 1);
    #3 rst_i = 1'b0;
    #1;
    check("mr_rst_en", cnt_en_o, 0);
    check("mr_rst_we", cnt_we_o, 0);
    check("mr_rst_clr", cnt_clr_o, 0);
    check("mr_rst_dat", cnt_dat_o, 0);
    check("mr_rst_irq", irq_o, 0);
    check("mr_rst_busy", busy_o, 0);
    check("mr_rst_ovf", ovf_o, 0);
    step(); step();
    rst_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("mr_post_en_%0d", i), cnt_en_o, 0);
      check($sformatf("mr_post_we_%0d", i), cnt_we_o, 0);
      check($sformatf("mr_post_clr_%0d", i), cnt_clr_o, 0);
      check($sformatf("mr_post_busy_%0d", i), busy_o, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: width of count, period and load values; it SHALL match the driven counter's WIDTH.
REQ-002 Parameter PRE_WIDTH, default 8: prescaler width.
REQ-003 clk_i  in  1: sole clock, rising edge.
REQ-004 rst_i  in  1: reset, asynchronous, active-low.
REQ-005 start_i  in  1: start pulse.
REQ-006 stop_i  in  1: abort pulse.
REQ-007 mode_i  in  1: 0 = one-shot, 1 = periodic; sampled on accepted start.
REQ-008 prescale_i  in  PRE_WIDTH: tick divider; a tick occurs every prescale_i+1 cycles; sampled on accepted start.
REQ-009 period_i  in  WIDTH: terminal count; sampled on accepted start.
REQ-010 load_i  in  WIDTH: initial count; sampled on accepted start.
REQ-011 cnt_i  in  WIDTH: current value of the downstream counter.
REQ-012 cnt_clr_o  out  1: counter clear.
REQ-013 cnt_en_o  out  1: counter increment enable.
REQ-014 cnt_we_o  out  1: counter load strobe.
REQ-015 cnt_dat_o  out  WIDTH: counter load value.
REQ-016 irq_o  out  1: terminal-count interrupt, level, sticky until acknowledged.
REQ-017 irq_ack_i  in  1: interrupt acknowledge pulse.
REQ-018 busy_o  out  1: high in LOAD and RUN.
REQ-019 ovf_o  out  1: missed-interrupt flag (see Configuration).

Function
REQ-020 The FSM SHALL have states IDLE, LOAD, RUN, DONE; all outputs SHALL be registered.
REQ-021 IDLE/DONE + start_i -> LOAD; latch mode, prescale, period, load; start_i in LOAD/RUN SHALL be ignored.
REQ-022 LOAD (1 cycle): cnt_we_o=1, cnt_dat_o=latched load; prescaler cleared; -> RUN.
REQ-023 RUN: the prescaler counts 0..latched prescale; at terminal value a tick occurs and the prescaler returns to 0; prescale 0 SHALL tick every cycle.
REQ-024 Tick with cnt_i != period: cnt_en_o=1 for exactly 1 cycle.
REQ-025 Tick with cnt_i == period: set irq_o; cnt_en_o=0; periodic -> cnt_we_o=1 with latched load, stay RUN; one-shot -> DONE.
REQ-026 Ticks SHALL be spaced >=2 cycles apart when prescale >= 1; with prescale 0 the match compare SHALL use cnt_i after the previous increment has landed (1-cycle counter latency accounted for by suppressing compare on the cycle after cnt_en_o/cnt_we_o).
REQ-027 Load > period: count runs up, wraps modulo 2^WIDTH, and matches on the next pass; no special handling.
REQ-028 stop_i in any state: cnt_clr_o=1 for 1 cycle, -> IDLE; irq_o unaffected; stop_i SHALL take priority over start_i and tick.
REQ-029 irq_ack_i SHALL clear irq_o next cycle; a simultaneous match and ack SHALL leave irq_o set.
REQ-030 cnt_clr_o, cnt_en_o and cnt_we_o SHALL be mutually exclusive in every cycle.
REQ-031 DONE: counter outputs idle; busy_o=0; hold until start_i or stop_i.

Reset
REQ-032 rst_i low SHALL immediately force IDLE, prescaler 0, all outputs 0, and latched config 0.
REQ-033 Reset deassertion mid-operation SHALL NOT resume; a new start_i is required.

Configuration
REQ-034 Macro TIMER_CTRL_OVF_EN defined: a match while irq_o is already set (and no ack in that cycle) SHALL set ovf_o, cleared only by irq_ack_i or reset.
REQ-035 TIMER_CTRL_OVF_EN undefined: ovf_o SHALL be constant 0 and no overflow logic is built.

Verification
REQ-036 Reset low mid-RUN -> all outputs 0 that cycle, state IDLE after release, no counter strobes.
REQ-037 One-shot, prescale=0, load=0, period=3 -> 1 we, then 3 en pulses, irq_o set at 4th tick, DONE, busy_o=0.
REQ-038 Periodic, prescale=2, load=5, period=7 -> en every 3rd cycle, reload to 5 at match, irq each wrap, cycle count per wrap = 9.
REQ-039 stop_i coincident with tick and start_i -> only cnt_clr_o asserted, IDLE next.
REQ-040 irq_ack_i same cycle as a match -> irq_o stays 1.
REQ-041 With TIMER_CTRL_OVF_EN, two matches without ack -> ovf_o=1; ack -> irq_o=0, ovf_o=0; without macro, ovf_o stays 0.
